// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// per-stage control bundle and the control pattern of each priority row.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } stage_ctrl_t;

    // Winning stall/flush source, listed from highest to lowest priority
    typedef enum logic [2:0] {
        ROW_MEM    = 3'd0,
        ROW_MC     = 3'd1,
        ROW_BRANCH = 3'd2,
        ROW_LDR    = 3'd3,
        ROW_NONE   = 3'd4
    } ctrl_row_t;

    localparam stage_ctrl_t CTRL_NONE   = '0;
    localparam stage_ctrl_t CTRL_MEM    = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
                                            flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0, flush_w: 1'b1};
    localparam stage_ctrl_t CTRL_MC     = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b0,
                                            flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b1, flush_w: 1'b0};
    localparam stage_ctrl_t CTRL_BRANCH = '{stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0, stall_m: 1'b0,
                                            flush_d: 1'b1, flush_e: 1'b1, flush_m: 1'b0, flush_w: 1'b0};
    localparam stage_ctrl_t CTRL_LDR    = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b0, stall_m: 1'b0,
                                            flush_d: 1'b0, flush_e: 1'b1, flush_m: 1'b0, flush_w: 1'b0};

    function automatic stage_ctrl_t row_ctrl(input ctrl_row_t row);
        stage_ctrl_t c;
        case (row)
            ROW_MEM:    c = CTRL_MEM;
            ROW_MC:     c = CTRL_MC;
            ROW_BRANCH: c = CTRL_BRANCH;
            ROW_LDR:    c = CTRL_LDR;
            default:    c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-source inputs and per-stage control outputs of the pipeline sequencer.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             LDRHazardD;
    logic             BranchTakenE;
    logic             PCSrcW;
    logic             McStartE;
    logic             McDoneE;
    logic             MemReqM;
    logic             MemReadyM;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             FlushW;
    logic             McBusy;
    logic             TimeoutErr;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output LDRHazardD, BranchTakenE, PCSrcW, McStartE, McDoneE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        input  McBusy, TimeoutErr, StallCount
    );

    modport slave (
        input  LDRHazardD, BranchTakenE, PCSrcW, McStartE, McDoneE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        output McBusy, TimeoutErr, StallCount
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for stall-cycle profiling.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (inc && (q_reg != {W{1'b1}})) begin
            q_next = q_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory, multi-cycle,
// branch and load-use sources into one control set and profiles stall cycles.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_ctrl_if.slave        bus
);
    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(MC_TIMEOUT - 1);

    ctrl_state_t   state_reg, state_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic          err_reg, err_next;

    logic          mem_stall;
    logic          mc_stall;
    logic          timeout;
    ctrl_row_t     row;
    stage_ctrl_t   ctrl;
    logic [CNT_W-1:0] stall_count;

    assign mem_stall = bus.MemReqM & ~bus.MemReadyM;
    assign timeout   = (state_reg == MC_BUSY) && (tcnt_reg == TCNT_LAST);
    assign mc_stall  = ((state_reg == RUN) && bus.McStartE) ||
                       ((state_reg == MC_BUSY) && !bus.McDoneE && !timeout);

    always_comb begin
        row = ROW_NONE;
        if (mem_stall) begin
            row = ROW_MEM;
        end else if (mc_stall) begin
            row = ROW_MC;
        end else if (bus.BranchTakenE) begin
            row = ROW_BRANCH;
        end else if (bus.LDRHazardD) begin
            row = ROW_LDR;
        end
    end

    // A PC write from W squashes D on top of any row except a memory hold
    always_comb begin
        ctrl = row_ctrl(row);
        if (bus.PCSrcW && !mem_stall) begin
            ctrl.flush_d = 1'b1;
        end
        if (rst) begin
            ctrl = CTRL_NONE;
        end
    end

    always_comb begin
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
        err_next   = err_reg;
        case (state_reg)
            RUN: begin
                tcnt_next = '0;
                if (bus.McStartE && !mem_stall) begin
                    state_next = MC_BUSY;
                end
            end
            MC_BUSY: begin
                // Done wins over a coincident timeout, so no error is raised then
                if (bus.McDoneE) begin
                    state_next = RUN;
                    tcnt_next  = '0;
                end else if (timeout) begin
                    state_next = RUN;
                    tcnt_next  = '0;
                    err_next   = 1'b1;
                end else begin
                    tcnt_next  = tcnt_reg + TW'(1);
                end
            end
            default: begin
                state_next = RUN;
                tcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            tcnt_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
            err_reg   <= err_next;
        end
    end

    sat_counter #(
        .W   (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.stall_f),
        .q   (stall_count)
    );

    assign bus.StallF     = ctrl.stall_f;
    assign bus.StallD     = ctrl.stall_d;
    assign bus.StallE     = ctrl.stall_e;
    assign bus.StallM     = ctrl.stall_m;
    assign bus.FlushD     = ctrl.flush_d;
    assign bus.FlushE     = ctrl.flush_e;
    assign bus.FlushM     = ctrl.flush_m;
    assign bus.FlushW     = ctrl.flush_w;
    assign bus.McBusy     = !rst && (state_reg == MC_BUSY);
    assign bus.TimeoutErr = !rst && err_reg;
    assign bus.StallCount = rst ? '0 : stall_count;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random traffic,
// each cycle checked against a cycle-level reference model of the control rules.
module tb_pipeline_ctrl;
    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 5;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int               id;
        logic [7:0]       ctrl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
        logic             busy;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model state
    bit   m_busy = 0;
    int   m_bcyc = 0;   // 1-based index of the current busy cycle
    bit   m_err  = 0;
    int   m_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input bit r, input bit ldr, input bit br, input bit pcs,
                        input bit st, input bit dn, input bit req, input bit rdy);
        exp_t e;
        bit   mem, tmo, mc;
        @(posedge clk);
        #1;
        rst              = r;
        bus.LDRHazardD   = ldr;
        bus.BranchTakenE = br;
        bus.PCSrcW       = pcs;
        bus.McStartE     = st;
        bus.McDoneE      = dn;
        bus.MemReqM      = req;
        bus.MemReadyM    = rdy;
        e.id = txn;
        txn++;
        if (r) begin
            e.ctrl = 8'b0; e.busy = 0; e.err = 0; e.cnt = '0;
            m_busy = 0; m_bcyc = 0; m_err = 0; m_cnt = 0;
        end else begin
            mem = req && !rdy;
            tmo = m_busy && (m_bcyc == MC_TIMEOUT);
            mc  = (!m_busy && st) || (m_busy && !dn && !tmo);
            if (mem)      e.ctrl = 8'b1111_0001;
            else if (mc)  e.ctrl = 8'b1110_0010;
            else if (br)  e.ctrl = 8'b0000_1100;
            else if (ldr) e.ctrl = 8'b1100_0100;
            else          e.ctrl = 8'b0000_0000;
            if (pcs && !mem) e.ctrl[3] = 1'b1;
            e.busy = m_busy;
            e.err  = m_err;
            e.cnt  = CNT_W'(m_cnt);
            if (e.ctrl[7]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (!m_busy) begin
                if (st && !mem) begin
                    m_busy = 1; m_bcyc = 1;
                end
            end else if (dn) begin
                m_busy = 0;
            end else if (tmo) begin
                m_busy = 0; m_err = 1;
            end else begin
                m_bcyc++;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle, sampled mid-cycle
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                       bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL txn %0d ctrl: got %b expected %b", e.id, act, e.ctrl);
                end
                checks++;
                if (bus.McBusy !== e.busy) begin
                    errors++;
                    $display("FAIL txn %0d McBusy: got %b expected %b", e.id, bus.McBusy, e.busy);
                end
                checks++;
                if (bus.TimeoutErr !== e.err) begin
                    errors++;
                    $display("FAIL txn %0d TimeoutErr: got %b expected %b", e.id, bus.TimeoutErr, e.err);
                end
                checks++;
                if (bus.StallCount !== e.cnt) begin
                    errors++;
                    $display("FAIL txn %0d StallCount: got %0d expected %0d", e.id, bus.StallCount, e.cnt);
                end
                $display("txn %0d rst=%b in{ldr,br,pcs,st,dn,req,rdy}=%b%b%b%b%b%b%b ctrl=%b busy=%b err=%b cnt=%0d",
                         e.id, rst, bus.LDRHazardD, bus.BranchTakenE, bus.PCSrcW, bus.McStartE,
                         bus.McDoneE, bus.MemReqM, bus.MemReadyM, act, bus.McBusy, bus.TimeoutErr,
                         bus.StallCount);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.LDRHazardD = 0; bus.BranchTakenE = 0; bus.PCSrcW = 0; bus.McStartE = 0;
        bus.McDoneE = 0; bus.MemReqM = 0; bus.MemReadyM = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Load-use alone, then branch masking load-use
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        // Multi-cycle op with done on the 4th busy cycle
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // Timeout with no done, then sticky error
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(MC_TIMEOUT + 3);
        // Memory wait over a busy multi-cycle op, done in 2nd memory cycle
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 1, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // McStartE under memory stall is ignored; done with timeout counts as done
        step(0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(MC_TIMEOUT - 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        // Reset mid-busy
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(127) == 0),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 10),
                 ($urandom_range(99) < 10),
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 30),
                 ($urandom_range(99) < 50));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
